// File: rtl/amba_axi_pkg.sv
// ----------------------------------------------------------------------------
// amba_axi_pkg
// Shared AXI4 channel types used across the JTAG-to-AXI path.
//   s_axi_mosi_t : AW/W/AR channels plus bready/rready (master -> slave)
//   s_axi_miso_t : awready/wready/arready plus B and R channels (slave -> master)
//   axi_resp_t   : BRESP/RRESP encodings
// Burst encodings are provided as localparams so FIXED/INCR/WRAP can be
// compared directly against the raw awburst/arburst fields.
// ----------------------------------------------------------------------------
package amba_axi_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     awid;
        logic [AXI_ADDR_WIDTH-1:0]   awaddr;
        logic [7:0]                  awlen;
        logic [2:0]                  awsize;
        logic [1:0]                  awburst;
        logic                        awvalid;
        logic [AXI_DATA_WIDTH-1:0]   wdata;
        logic [AXI_DATA_WIDTH/8-1:0] wstrb;
        logic                        wlast;
        logic                        wvalid;
        logic                        bready;
        logic [AXI_ID_WIDTH-1:0]     arid;
        logic [AXI_ADDR_WIDTH-1:0]   araddr;
        logic [7:0]                  arlen;
        logic [2:0]                  arsize;
        logic [1:0]                  arburst;
        logic                        arvalid;
        logic                        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                      awready;
        logic                      wready;
        logic [AXI_ID_WIDTH-1:0]   bid;
        axi_resp_t                 bresp;
        logic                      bvalid;
        logic                      arready;
        logic [AXI_ID_WIDTH-1:0]   rid;
        logic [AXI_DATA_WIDTH-1:0] rdata;
        axi_resp_t                 rresp;
        logic                      rlast;
        logic                      rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/jtag_axi_pkg.sv
// ----------------------------------------------------------------------------
// jtag_axi_pkg
// Types and helpers shared by the JTAG-to-AXI blocks.
//   axi_slv_wr_st_t : write-side FSM states of the memory slave
//   axi_slv_rd_st_t : read-side FSM states of the memory slave
//   axi_slv_req_t   : address-phase fields captured at the AW/AR handshake
//   axi_next_addr   : per-beat address step shared by both FSMs
// ----------------------------------------------------------------------------
package jtag_axi_pkg;
    import amba_axi_pkg::*;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } axi_slv_wr_st_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } axi_slv_rd_st_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_slv_req_t;

    // FIXED bursts keep hammering the same address; WRAP is deliberately
    // folded into INCR because the slave has no wrap-boundary logic.
    // The add simply rolls over at the top of the address space.
    function automatic logic [AXI_ADDR_WIDTH-1:0] axi_next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] step;
        step = AXI_ADDR_WIDTH'(1) << size;
        if (burst == AXI_BURST_FIXED) begin
            return addr;
        end
        return addr + step;
    endfunction

endpackage

// File: rtl/jtag_axi_slave_ram.sv
// ----------------------------------------------------------------------------
// jtag_axi_slave_ram
// Word-organised storage behind the AXI memory slave: one synchronous write
// port with per-byte enables and one asynchronous read port.
//   i_clk   : write clock (rising edge)
//   i_we    : write enable for the addressed word
//   i_waddr : write word index
//   i_wdata : write data
//   i_wstrb : byte enables, lane b covers bits [8b+7:8b]
//   i_raddr : read word index
//   o_rdata : combinational read data (pre-write content on a same-edge hit)
// Content is not reset; every word starts at INIT_PATTERN.
// ----------------------------------------------------------------------------
module jtag_axi_slave_ram
    import amba_axi_pkg::*;
#(
    parameter int unsigned               MEM_DEPTH    = 256,
    parameter logic [AXI_DATA_WIDTH-1:0] INIT_PATTERN = 32'hDEAD_BEEF
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [$clog2(MEM_DEPTH)-1:0]  i_waddr,
    input  logic [AXI_DATA_WIDTH-1:0]     i_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   i_wstrb,
    input  logic [$clog2(MEM_DEPTH)-1:0]  i_raddr,
    output logic [AXI_DATA_WIDTH-1:0]     o_rdata
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH] = '{default: INIT_PATTERN};

    // Only the enabled byte lanes of the addressed word are touched.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jtag_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// jtag_axi_slave_mem
// AXI4 slave responder backed by a small on-chip RAM; the far end of the
// JTAG-to-AXI master path in integration benches and bring-up images.
//   clk_axi    : AXI clock, all logic rising-edge
//   ares_axi   : asynchronous active-low reset (RAM content survives it)
//   axi_mosi_i : AW/W/AR channels and bready/rready from the master
//   axi_miso_o : registered readies plus B and R channels
//   stall_i    : blocks new readies and the raising of new valids
//   err_cnt_o  : saturating count of SLVERR B responses and R beats
// Independent write and read FSMs, one outstanding transaction each.
// Accesses outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*bytes) answer SLVERR.
// ----------------------------------------------------------------------------
module jtag_axi_slave_mem
    import amba_axi_pkg::*, jtag_axi_pkg::*;
#(
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned               MEM_DEPTH    = 256,
    parameter logic [AXI_DATA_WIDTH-1:0] INIT_PATTERN = 32'hDEAD_BEEF
) (
    input  logic        clk_axi,
    input  logic        ares_axi,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o,
    input  logic        stall_i,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * BYTES);

    function automatic logic f_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return ((a - BASE_ADDR) < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    // write side
    axi_slv_wr_st_t            r_wr_st;
    axi_slv_req_t              r_wr_req;
    logic [7:0]                r_wr_beat;
    logic                      r_wr_err;
    logic                      r_awready;
    logic                      r_wready;
    logic                      r_bvalid;
    axi_resp_t                 r_bresp;
    logic [AXI_ID_WIDTH-1:0]   r_bid;

    // read side
    axi_slv_rd_st_t            r_rd_st;
    axi_slv_req_t              r_rd_req;
    logic [7:0]                r_rd_beat;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    axi_resp_t                 r_rresp;
    logic                      r_rlast;
    logic [AXI_ID_WIDTH-1:0]   r_rid;

    logic [15:0]               r_err_cnt;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_b_hs;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_wr_hit;
    logic                      w_wlast_bad;
    logic                      w_wr_err_next;
    logic [AXI_ADDR_WIDTH-1:0] w_rd_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_rd_next;
    logic                      w_rd_hit;
    logic [AXI_DATA_WIDTH-1:0] w_ram_rdata;
    logic [1:0]                w_err_inc;
    logic [16:0]               w_err_sum;

    assign w_aw_hs  = (r_wr_st == W_IDLE) && axi_mosi_i.awvalid && r_awready;
    assign w_w_hs   = (r_wr_st == W_DATA) && axi_mosi_i.wvalid && r_wready;
    assign w_b_hs   = r_bvalid && axi_mosi_i.bready;
    assign w_ar_hs  = (r_rd_st == R_IDLE) && axi_mosi_i.arvalid && r_arready;
    assign w_r_hs   = r_rvalid && axi_mosi_i.rready;

    // A beat is bad if it falls outside the window or if wlast disagrees
    // with the beat count announced on AW.
    assign w_wr_hit      = f_in_range(r_wr_req.addr);
    assign w_wlast_bad   = axi_mosi_i.wlast != (r_wr_beat == r_wr_req.len);
    assign w_wr_err_next = r_wr_err | ~w_wr_hit | w_wlast_bad;

    // The single read port must present whichever beat is loaded on the
    // coming edge: the AR address from idle, the advanced address on an R
    // handshake, otherwise the current beat (for a stall-delayed raise).
    assign w_rd_next = axi_next_addr(r_rd_req.addr, r_rd_req.size, r_rd_req.burst);

    always_comb begin
        w_rd_addr = r_rd_req.addr;
        if (r_rd_st == R_IDLE) begin
            w_rd_addr = axi_mosi_i.araddr;
        end else if (w_r_hs) begin
            w_rd_addr = w_rd_next;
        end
    end

    assign w_rd_hit = f_in_range(w_rd_addr);

    jtag_axi_slave_ram #(
        .MEM_DEPTH    (MEM_DEPTH),
        .INIT_PATTERN (INIT_PATTERN)
    ) u_ram (
        .i_clk   (clk_axi),
        .i_we    (w_w_hs && w_wr_hit),
        .i_waddr (f_idx(r_wr_req.addr)),
        .i_wdata (axi_mosi_i.wdata),
        .i_wstrb (axi_mosi_i.wstrb),
        .i_raddr (f_idx(w_rd_addr)),
        .o_rdata (w_ram_rdata)
    );

    // Write FSM. bvalid is normally raised on the wlast edge; if stall_i is
    // high then, W_RESP raises it once the stall clears.
    always_ff @(posedge clk_axi or negedge ares_axi) begin
        if (!ares_axi) begin
            r_wr_st   <= W_IDLE;
            r_wr_req  <= '0;
            r_wr_beat <= 8'd0;
            r_wr_err  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_RESP_OKAY;
            r_bid     <= '0;
        end else begin
            case (r_wr_st)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr_req.id    <= axi_mosi_i.awid;
                        r_wr_req.addr  <= axi_mosi_i.awaddr;
                        r_wr_req.len   <= axi_mosi_i.awlen;
                        r_wr_req.size  <= axi_mosi_i.awsize;
                        r_wr_req.burst <= axi_mosi_i.awburst;
                        r_bid          <= axi_mosi_i.awid;
                        r_wr_beat      <= 8'd0;
                        r_wr_err       <= 1'b0;
                        r_awready      <= 1'b0;
                        r_wready       <= !stall_i;
                        r_wr_st        <= W_DATA;
                    end else begin
                        r_awready <= !stall_i;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wr_req.addr <= axi_next_addr(r_wr_req.addr, r_wr_req.size, r_wr_req.burst);
                        r_wr_beat     <= r_wr_beat + 8'd1;
                        r_wr_err      <= w_wr_err_next;
                        if (axi_mosi_i.wlast) begin
                            r_wready <= 1'b0;
                            r_wr_st  <= W_RESP;
                            if (!stall_i) begin
                                r_bvalid <= 1'b1;
                                r_bresp  <= w_wr_err_next ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            end
                        end else begin
                            r_wready <= !stall_i;
                        end
                    end else begin
                        r_wready <= !stall_i;
                    end
                end
                W_RESP: begin
                    if (!r_bvalid) begin
                        if (!stall_i) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= r_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        end
                    end else if (axi_mosi_i.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= !stall_i;
                        r_wr_st   <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_st <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM. Each edge that loads a beat samples the RAM through
    // w_rd_addr, so consecutive beats go out back-to-back while rready is
    // high; a stall only postpones raising rvalid, never drops it.
    always_ff @(posedge clk_axi or negedge ares_axi) begin
        if (!ares_axi) begin
            r_rd_st   <= R_IDLE;
            r_rd_req  <= '0;
            r_rd_beat <= 8'd0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= AXI_RESP_OKAY;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
        end else if (r_rd_st == R_IDLE) begin
            if (w_ar_hs) begin
                r_rd_req.id    <= axi_mosi_i.arid;
                r_rd_req.addr  <= axi_mosi_i.araddr;
                r_rd_req.len   <= axi_mosi_i.arlen;
                r_rd_req.size  <= axi_mosi_i.arsize;
                r_rd_req.burst <= axi_mosi_i.arburst;
                r_rid          <= axi_mosi_i.arid;
                r_rd_beat      <= 8'd0;
                r_arready      <= 1'b0;
                r_rd_st        <= R_DATA;
                if (!stall_i) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rd_hit ? w_ram_rdata : '0;
                    r_rresp  <= w_rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    r_rlast  <= (axi_mosi_i.arlen == 8'd0);
                end
            end else begin
                r_arready <= !stall_i;
            end
        end else begin
            if (!r_rvalid) begin
                if (!stall_i) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rd_hit ? w_ram_rdata : '0;
                    r_rresp  <= w_rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    r_rlast  <= (r_rd_beat == r_rd_req.len);
                end
            end else if (axi_mosi_i.rready) begin
                if (r_rlast) begin
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                    r_arready <= !stall_i;
                    r_rd_st   <= R_IDLE;
                end else begin
                    r_rd_req.addr <= w_rd_next;
                    r_rd_beat     <= r_rd_beat + 8'd1;
                    if (!stall_i) begin
                        r_rdata <= w_rd_hit ? w_ram_rdata : '0;
                        r_rresp <= w_rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_rlast <= ((r_rd_beat + 8'd1) == r_rd_req.len);
                    end else begin
                        r_rvalid <= 1'b0;
                    end
                end
            end
        end
    end

    // Errors are counted when the master accepts them; a B and an R error
    // can land on the same edge, hence the two-bit increment.
    assign w_err_inc = {1'b0, w_b_hs && (r_bresp == AXI_RESP_SLVERR)}
                     + {1'b0, w_r_hs && (r_rresp == AXI_RESP_SLVERR)};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

    always_ff @(posedge clk_axi or negedge ares_axi) begin
        if (!ares_axi) begin
            r_err_cnt <= 16'd0;
        end else begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_cnt_o = r_err_cnt;

    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.awready = r_awready;
        axi_miso_o.wready  = r_wready;
        axi_miso_o.bid     = r_bid;
        axi_miso_o.bresp   = r_bresp;
        axi_miso_o.bvalid  = r_bvalid;
        axi_miso_o.arready = r_arready;
        axi_miso_o.rid     = r_rid;
        axi_miso_o.rdata   = r_rdata;
        axi_miso_o.rresp   = r_rresp;
        axi_miso_o.rlast   = r_rlast;
        axi_miso_o.rvalid  = r_rvalid;
    end

endmodule

// File: tb/tb_jtag_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_jtag_axi_slave_mem
// Directed bench for the AXI memory slave: single and strobed writes, INCR
// and FIXED bursts, out-of-window SLVERR, wlast protocol error, stall
// behaviour and asynchronous reset in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_jtag_axi_slave_mem;
    import amba_axi_pkg::*;

    logic        clk_axi = 1'b0;
    logic        ares_axi;
    logic        stall_i;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] wBuf  [16];
    logic [3:0]  sBuf  [16];
    logic [31:0] rdBuf [16];
    logic [1:0]  rrBuf [16];
    logic        rlBuf [16];
    logic [3:0]  riBuf [16];
    int          rdCount;
    logic [1:0]  lastBresp;
    logic [3:0]  lastBid;
    logic        seenReady;

    jtag_axi_slave_mem #(
        .BASE_ADDR    (32'h0000_0000),
        .MEM_DEPTH    (256),
        .INIT_PATTERN (32'hDEAD_BEEF)
    ) dut (
        .clk_axi    (clk_axi),
        .ares_axi   (ares_axi),
        .axi_mosi_i (mosi),
        .axi_miso_o (miso),
        .stall_i    (stall_i),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk_axi = ~clk_axi;

    // Hard stop in case a handshake loop never terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic sigSel(input int which);
        case (which)
            0:       return miso.awready;
            1:       return miso.wready;
            2:       return miso.bvalid;
            3:       return miso.arready;
            default: return miso.rvalid;
        endcase
    endfunction

    // Waits a bounded number of cycles for a ready/valid; expiry is a failure.
    task automatic waitSig(input string tag, input int which);
        int n;
        n = 0;
        while (!sigSel(which) && n < 50) begin
            @(posedge clk_axi); #1;
            n++;
        end
        checkOutput(tag, 32'(sigSel(which)), 32'd1);
    endtask

    // One complete write transaction from wBuf/sBuf; wlast goes on lastBeat.
    task automatic applyStimulus(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [1:0] burst, input int lastBeat);
        mosi.awid    = id;
        mosi.awaddr  = addr;
        mosi.awlen   = len;
        mosi.awsize  = 3'd2;
        mosi.awburst = burst;
        mosi.awvalid = 1'b1;
        waitSig({tag, "_awready"}, 0);
        @(posedge clk_axi); #1;
        mosi.awvalid = 1'b0;
        for (int b = 0; b <= lastBeat; b++) begin
            mosi.wdata  = wBuf[b];
            mosi.wstrb  = sBuf[b];
            mosi.wlast  = (b == lastBeat);
            mosi.wvalid = 1'b1;
            waitSig({tag, "_wready"}, 1);
            @(posedge clk_axi); #1;
        end
        mosi.wvalid = 1'b0;
        mosi.wlast  = 1'b0;
        mosi.bready = 1'b1;
        waitSig({tag, "_bvalid"}, 2);
        lastBresp = miso.bresp;
        lastBid   = miso.bid;
        @(posedge clk_axi); #1;
        mosi.bready = 1'b0;
    endtask

    // One read transaction; beats are recorded into rdBuf/rrBuf/rlBuf/riBuf.
    task automatic readBurst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst, input logic toggle);
        int  cyc;
        logic done;
        mosi.arid    = id;
        mosi.araddr  = addr;
        mosi.arlen   = len;
        mosi.arsize  = 3'd2;
        mosi.arburst = burst;
        mosi.arvalid = 1'b1;
        waitSig({tag, "_arready"}, 3);
        @(posedge clk_axi); #1;
        mosi.arvalid = 1'b0;
        rdCount = 0;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < 200) begin
            mosi.rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (miso.rvalid && mosi.rready) begin
                if (rdCount < 16) begin
                    rdBuf[rdCount] = miso.rdata;
                    rrBuf[rdCount] = miso.rresp;
                    rlBuf[rdCount] = miso.rlast;
                    riBuf[rdCount] = miso.rid;
                end
                rdCount++;
                if (miso.rlast) done = 1'b1;
            end
            @(posedge clk_axi); #1;
            cyc++;
        end
        mosi.rready = 1'b0;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        mosi     = '0;
        stall_i  = 1'b0;
        ares_axi = 1'b0;
        repeat (3) @(posedge clk_axi);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_awready", 32'(miso.awready), 32'd0);
        checkOutput("rst_arready", 32'(miso.arready), 32'd0);
        checkOutput("rst_bvalid",  32'(miso.bvalid),  32'd0);
        checkOutput("rst_rvalid",  32'(miso.rvalid),  32'd0);
        checkOutput("rst_rdata",   miso.rdata,        32'd0);
        checkOutput("rst_errcnt",  32'(err_cnt),      32'd0);
        ares_axi = 1'b1;
        @(posedge clk_axi); #1;
        checkOutput("rel_awready", 32'(miso.awready), 32'd1);
        checkOutput("rel_arready", 32'(miso.arready), 32'd1);

        $display("[TB] single write then read");
        wBuf[0] = 32'hCAFE_F00D; sBuf[0] = 4'hF;
        applyStimulus("wr1", 4'd3, 32'h10, 8'd0, AXI_BURST_INCR, 0);
        checkOutput("wr1_bresp", 32'(lastBresp), 32'd0);
        checkOutput("wr1_bid",   32'(lastBid),   32'd3);
        readBurst("rd1", 4'd5, 32'h10, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd1_count", rdCount,       32'd1);
        checkOutput("rd1_data",  rdBuf[0],      32'hCAFE_F00D);
        checkOutput("rd1_rlast", 32'(rlBuf[0]), 32'd1);
        checkOutput("rd1_rresp", 32'(rrBuf[0]), 32'd0);
        checkOutput("rd1_rid",   32'(riBuf[0]), 32'd5);

        $display("[TB] byte strobes");
        wBuf[0] = 32'h1122_3344; sBuf[0] = 4'hF;
        applyStimulus("wr2a", 4'd1, 32'h20, 8'd0, AXI_BURST_INCR, 0);
        wBuf[0] = 32'hAABB_CCDD; sBuf[0] = 4'b0101;
        applyStimulus("wr2b", 4'd1, 32'h20, 8'd0, AXI_BURST_INCR, 0);
        checkOutput("wr2b_bresp", 32'(lastBresp), 32'd0);
        readBurst("rd2", 4'd2, 32'h20, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd2_data", rdBuf[0], 32'h11BB_33DD);

        $display("[TB] INCR burst of 4");
        for (int i = 0; i < 4; i++) begin
            wBuf[i] = 32'(i + 1);
            sBuf[i] = 4'hF;
        end
        applyStimulus("wr3", 4'd4, 32'h40, 8'd3, AXI_BURST_INCR, 3);
        checkOutput("wr3_bresp", 32'(lastBresp), 32'd0);
        readBurst("rd3", 4'd4, 32'h40, 8'd3, AXI_BURST_INCR, 1'b1);
        checkOutput("rd3_count", rdCount, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rd3_data%0d", i),  rdBuf[i],      32'(i + 1));
            checkOutput($sformatf("rd3_rlast%0d", i), 32'(rlBuf[i]), 32'(i == 3));
        end

        $display("[TB] FIXED burst and untouched word");
        readBurst("rd4", 4'd6, 32'h44, 8'd1, AXI_BURST_FIXED, 1'b0);
        checkOutput("rd4_count", rdCount,  32'd2);
        checkOutput("rd4_data0", rdBuf[0], 32'd2);
        checkOutput("rd4_data1", rdBuf[1], 32'd2);
        readBurst("rd5", 4'd6, 32'h80, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd5_init", rdBuf[0], 32'hDEAD_BEEF);

        $display("[TB] out of range");
        wBuf[0] = 32'h1234_5678; sBuf[0] = 4'hF;
        applyStimulus("wr6", 4'd1, 32'h400, 8'd0, AXI_BURST_INCR, 0);
        checkOutput("wr6_bresp",  32'(lastBresp), 32'd2);
        checkOutput("wr6_errcnt", 32'(err_cnt),   32'd1);
        readBurst("rd6", 4'd1, 32'h400, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd6_data",   rdBuf[0],       32'd0);
        checkOutput("rd6_rresp",  32'(rrBuf[0]),  32'd2);
        checkOutput("rd6_rlast",  32'(rlBuf[0]),  32'd1);
        checkOutput("rd6_errcnt", 32'(err_cnt),   32'd2);
        readBurst("rd7", 4'd1, 32'h0, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd7_word0", rdBuf[0], 32'hDEAD_BEEF);
        readBurst("rd8", 4'd1, 32'h3FC, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd8_last", rdBuf[0],     32'hDEAD_BEEF);
        checkOutput("rd8_resp", 32'(rrBuf[0]), 32'd0);

        $display("[TB] wlast protocol error");
        wBuf[0] = 32'h55; sBuf[0] = 4'hF;
        applyStimulus("wr9", 4'd2, 32'h60, 8'd1, AXI_BURST_INCR, 0);
        checkOutput("wr9_bresp",   32'(lastBresp),    32'd2);
        checkOutput("wr9_errcnt",  32'(err_cnt),      32'd3);
        checkOutput("wr9_awready", 32'(miso.awready), 32'd1);
        wBuf[0] = 32'h77; sBuf[0] = 4'hF;
        applyStimulus("wr10", 4'd6, 32'h64, 8'd0, AXI_BURST_INCR, 0);
        checkOutput("wr10_bresp", 32'(lastBresp), 32'd0);
        checkOutput("wr10_bid",   32'(lastBid),   32'd6);
        readBurst("rd10", 4'd0, 32'h64, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd10_data", rdBuf[0], 32'h77);

        $display("[TB] rvalid held across stall");
        mosi.arid = 4'd7; mosi.araddr = 32'h10; mosi.arlen = 8'd0;
        mosi.arsize = 3'd2; mosi.arburst = AXI_BURST_INCR; mosi.arvalid = 1'b1;
        waitSig("hold_arready", 3);
        @(posedge clk_axi); #1;
        mosi.arvalid = 1'b0;
        stall_i = 1'b1;
        repeat (3) begin
            @(posedge clk_axi); #1;
        end
        checkOutput("hold_rvalid",  32'(miso.rvalid),  32'd1);
        checkOutput("hold_rdata",   miso.rdata,        32'hCAFE_F00D);
        checkOutput("hold_rid",     32'(miso.rid),     32'd7);
        checkOutput("hold_arready", 32'(miso.arready), 32'd0);
        mosi.rready = 1'b1;
        @(posedge clk_axi); #1;
        mosi.rready = 1'b0;
        checkOutput("hold_rvalid_done", 32'(miso.rvalid), 32'd0);

        $display("[TB] long stall");
        mosi.awaddr = 32'h10; mosi.awvalid = 1'b1;
        mosi.araddr = 32'h10; mosi.arvalid = 1'b1;
        seenReady = 1'b0;
        repeat (5000) begin
            if (miso.awready || miso.arready) seenReady = 1'b1;
            @(posedge clk_axi); #1;
        end
        checkOutput("stall_ready_seen", 32'(seenReady),   32'd0);
        checkOutput("stall_bvalid",     32'(miso.bvalid), 32'd0);
        checkOutput("stall_rvalid",     32'(miso.rvalid), 32'd0);
        mosi.awvalid = 1'b0;
        mosi.arvalid = 1'b0;
        stall_i = 1'b0;
        @(posedge clk_axi); #1;
        checkOutput("unstall_awready", 32'(miso.awready), 32'd1);
        checkOutput("unstall_arready", 32'(miso.arready), 32'd1);

        $display("[TB] reset mid-burst");
        mosi.arid = 4'd1; mosi.araddr = 32'h40; mosi.arlen = 8'd3; mosi.arvalid = 1'b1;
        mosi.awid = 4'd1; mosi.awaddr = 32'h40; mosi.awlen = 8'd3;
        mosi.awsize = 3'd2; mosi.awburst = AXI_BURST_INCR; mosi.awvalid = 1'b1;
        @(posedge clk_axi); #1;
        mosi.arvalid = 1'b0;
        mosi.awvalid = 1'b0;
        checkOutput("mid_rvalid", 32'(miso.rvalid), 32'd1);
        checkOutput("mid_wready", 32'(miso.wready), 32'd1);
        #3;
        ares_axi = 1'b0;
        #1;
        checkOutput("async_rvalid",  32'(miso.rvalid),  32'd0);
        checkOutput("async_wready",  32'(miso.wready),  32'd0);
        checkOutput("async_awready", 32'(miso.awready), 32'd0);
        checkOutput("async_arready", 32'(miso.arready), 32'd0);
        checkOutput("async_bvalid",  32'(miso.bvalid),  32'd0);
        checkOutput("async_errcnt",  32'(err_cnt),      32'd0);
        mosi = '0;
        @(posedge clk_axi); #1;
        ares_axi = 1'b1;
        @(posedge clk_axi); #1;
        checkOutput("post_awready", 32'(miso.awready), 32'd1);
        checkOutput("post_arready", 32'(miso.arready), 32'd1);
        readBurst("rd11", 4'd3, 32'h40, 8'd0, AXI_BURST_INCR, 1'b0);
        checkOutput("rd11_kept", rdBuf[0], 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
